// File: rtl/kbd_pkg.sv
// kbd_pkg: shared constants, state type and BCD helper for the keyboard display tracker
package kbd_pkg;
  localparam logic [7:0] KBD_BREAK = 8'hF0;
  localparam logic [7:0] KBD_EXT   = 8'hE0;
  localparam int DIG_SCAN_LO  = 0;
  localparam int DIG_SCAN_HI  = 1;
  localparam int DIG_ASC_LO   = 2;
  localparam int DIG_ASC_HI   = 3;
  localparam int DIG_CNT_ONES = 4;
  localparam int DIG_CNT_TENS = 5;
  typedef enum logic [1:0] {IDLE, HELD, BREAK} kbd_state_e;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {(v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1, 4'd0}
                            : {v[7:4], v[3:0] + 4'd1};
  endfunction
endpackage

// File: rtl/kbd_scan2ascii.sv
// kbd_scan2ascii: set-2 scan code to lowercase letter / main-row digit ASCII, 0 otherwise
module kbd_scan2ascii import kbd_pkg::*; (
  input  logic [7:0] code,
  input  logic       ext,
  output logic [7:0] ascii
);
  // extended codes never map to printable characters
  always_comb begin
    ascii = 8'h00;
    if (!ext)
      case (code)
        8'h1C: ascii = 8'h61;
        8'h32: ascii = 8'h62;
        8'h21: ascii = 8'h63;
        8'h23: ascii = 8'h64;
        8'h24: ascii = 8'h65;
        8'h2B: ascii = 8'h66;
        8'h34: ascii = 8'h67;
        8'h33: ascii = 8'h68;
        8'h43: ascii = 8'h69;
        8'h3B: ascii = 8'h6A;
        8'h42: ascii = 8'h6B;
        8'h4B: ascii = 8'h6C;
        8'h3A: ascii = 8'h6D;
        8'h31: ascii = 8'h6E;
        8'h44: ascii = 8'h6F;
        8'h4D: ascii = 8'h70;
        8'h15: ascii = 8'h71;
        8'h2D: ascii = 8'h72;
        8'h1B: ascii = 8'h73;
        8'h2C: ascii = 8'h74;
        8'h3C: ascii = 8'h75;
        8'h2A: ascii = 8'h76;
        8'h1D: ascii = 8'h77;
        8'h22: ascii = 8'h78;
        8'h35: ascii = 8'h79;
        8'h1A: ascii = 8'h7A;
        8'h45: ascii = 8'h30;
        8'h16: ascii = 8'h31;
        8'h1E: ascii = 8'h32;
        8'h26: ascii = 8'h33;
        8'h25: ascii = 8'h34;
        8'h2E: ascii = 8'h35;
        8'h36: ascii = 8'h36;
        8'h3D: ascii = 8'h37;
        8'h3E: ascii = 8'h38;
        8'h46: ascii = 8'h39;
        default: ascii = 8'h00;
      endcase
  end
endmodule

// File: rtl/kbd_disp_ctrl.sv
// kbd_disp_ctrl: tracks PS/2 make/break/extended bytes and drives six digit nibbles
module kbd_disp_ctrl import kbd_pkg::*; #(
  parameter int TO_W = 20,
  parameter logic [TO_W-1:0] BREAK_TIMEOUT = 20'd500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [23:0] dig_nib,
  output logic [5:0]  dig_blank,
  output logic        key_held,
  output logic [7:0]  press_cnt
);
  localparam logic [TO_W-1:0] TO_LAST = BREAK_TIMEOUT - 1'b1;
  kbd_state_e state, state_d, prev, prev_d;
  logic ext, ext_d, held, held_d, load;
  logic [7:0] code, code_d, cnt, cnt_d, scan, scan_d, asc, asc_d, lut;
  logic [3:0] blank, blank_d;
  logic [TO_W-1:0] to, to_d;
  kbd_scan2ascii u_lut (.code(byte_in), .ext(ext), .ascii(lut));
  // register all tracker state; prev remembers where BREAK was entered from
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      prev  <= IDLE;
      ext   <= 1'b0;
      held  <= 1'b0;
      code  <= 8'h00;
      cnt   <= 8'h00;
      scan  <= 8'h00;
      asc   <= 8'h00;
      blank <= 4'hF;
      to    <= '0;
    end else begin
      state <= state_d;
      prev  <= prev_d;
      ext   <= ext_d;
      held  <= held_d;
      code  <= code_d;
      cnt   <= cnt_d;
      scan  <= scan_d;
      asc   <= asc_d;
      blank <= blank_d;
      to    <= to_d;
    end
  // byte decode, break timeout and press loading
  always_comb begin
    state_d = state;
    prev_d  = prev;
    ext_d   = ext;
    held_d  = held;
    code_d  = code;
    cnt_d   = cnt;
    scan_d  = scan;
    asc_d   = asc;
    blank_d = blank;
    to_d    = (state == BREAK) ? to + 1'b1 : '0;
    load    = 1'b0;
    if (byte_valid) begin
      to_d = '0;
      if (byte_in == KBD_EXT)
        ext_d = 1'b1;
      else if (byte_in == KBD_BREAK) begin
        prev_d  = (state == BREAK) ? prev : state;
        state_d = BREAK;
      end else begin
        ext_d = 1'b0;
        case (state)
          IDLE: load = 1'b1;
          HELD: load = byte_in != code;
          default:
            if (byte_in == code && held) begin
              state_d = IDLE;
              held_d  = 1'b0;
              blank_d = 4'hF;
            end else
              state_d = prev;
        endcase
      end
    end else if (state == BREAK && to == TO_LAST) begin
      state_d = prev;
      to_d    = '0;
    end
    if (load) begin
      state_d = HELD;
      held_d  = 1'b1;
      code_d  = byte_in;
      cnt_d   = bcd_inc(cnt);
      scan_d  = byte_in;
      asc_d   = lut;
      blank_d = 4'h0;
    end
  end
  // pack digit nibbles; count digits are never blanked
  always_comb begin
    dig_nib = '0;
    dig_nib[DIG_SCAN_LO*4 +: 8]  = scan;
    dig_nib[DIG_ASC_LO*4 +: 8]   = asc;
    dig_nib[DIG_CNT_ONES*4 +: 8] = cnt;
    dig_blank = '0;
    dig_blank[DIG_ASC_HI:DIG_SCAN_LO] = blank;
  end
  assign key_held  = held;
  assign press_cnt = cnt;
endmodule

// File: tb/tb_kbd_disp_ctrl.sv
// tb_kbd_disp_ctrl: directed and random byte streams checked against a behavioural model
module tb_kbd_disp_ctrl;
  localparam int T = 8;
  logic clk = 0, rst_n = 1, byte_valid = 0;
  logic [7:0] byte_in = 0;
  logic [23:0] dig_nib;
  logic [5:0] dig_blank;
  logic key_held;
  logic [7:0] press_cnt;
  int total = 0, bad = 0, cyc = 0;
  logic [7:0] lc [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,8'h42,8'h4B,8'h3A,
                         8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  logic [7:0] dc [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
  logic [7:0] pool [5] = '{8'h1C,8'h32,8'h75,8'h45,8'h16};
  bit m_down, m_brk, m_ext;
  int m_cnt, m_last;
  logic [7:0] m_code, m_scan, m_asc;
  kbd_disp_ctrl #(.BREAK_TIMEOUT(20'(T))) dut (
    .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_in(byte_in),
    .dig_nib(dig_nib), .dig_blank(dig_blank), .key_held(key_held), .press_cnt(press_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] asc_of(input logic [7:0] c);
    for (int i = 0; i < 26; i++) if (lc[i] == c) return 8'(8'h61 + i);
    for (int i = 0; i < 10; i++) if (dc[i] == c) return 8'(8'h30 + i);
    return 8'h00;
  endfunction
  task automatic m_reset();
    m_down = 0; m_brk = 0; m_ext = 0; m_cnt = 0; m_last = 0;
    m_code = 0; m_scan = 0; m_asc = 0;
  endtask
  task automatic m_byte(input logic [7:0] b, input int t);
    if (m_brk && t - m_last > T) m_brk = 0;
    m_last = t;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (m_brk) begin
        m_brk = 0;
        if (m_down && b == m_code) m_down = 0;
      end else if (!m_down || b != m_code) begin
        m_down = 1;
        m_code = b;
        m_scan = b;
        m_asc = m_ext ? 8'h00 : asc_of(b);
        m_cnt = (m_cnt + 1) % 100;
      end
      m_ext = 0;
    end
  endtask
  task automatic send(input logic [7:0] b, input int idle);
    @(negedge clk);
    byte_valid = 1;
    byte_in = b;
    m_byte(b, cyc);
    @(negedge clk);
    byte_valid = 0;
    byte_in = 8'($urandom);
    chk("nib", {8'h0, dig_nib}, {8'h0, 4'(m_cnt / 10), 4'(m_cnt % 10), m_asc, m_scan});
    chk("blank", {26'h0, dig_blank}, m_down ? 32'h0 : 32'h0F);
    chk("held", {31'h0, key_held}, {31'h0, m_down});
    chk("cnt", {24'h0, press_cnt}, {24'h0, 4'(m_cnt / 10), 4'(m_cnt % 10)});
    repeat (idle) @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_nib", {8'h0, dig_nib}, 32'h0);
    chk("rst_blank", {26'h0, dig_blank}, 32'h0F);
    chk("rst_held", {31'h0, key_held}, 32'h0);
    chk("rst_cnt", {24'h0, press_cnt}, 32'h0);
    m_reset();
    @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    m_reset();
    do_reset();
    send(8'h1C, 0);
    chk("a_code", {16'h0, dig_nib[15:0]}, 32'h611C);
    chk("a_cnt", {24'h0, press_cnt}, 32'h01);
    repeat (3) send(8'h1C, 0);
    chk("typ_cnt", {24'h0, press_cnt}, 32'h01);
    send(8'hF0, 0); send(8'h1C, 0);
    chk("rel_blank", {26'h0, dig_blank}, 32'h0F);
    chk("rel_held", {31'h0, key_held}, 32'h0);
    send(8'h1C, 1); send(8'h32, 0);
    chk("b_code", {8'h0, dig_nib}, 32'h036232);
    send(8'hF0, 0); send(8'h1C, 0);
    chk("other_rel", {31'h0, key_held}, 32'h1);
    send(8'hF0, 0); send(8'h32, 2);
    send(8'hE0, 0); send(8'h75, 0);
    chk("ext_code", {16'h0, dig_nib[15:0]}, 32'h0075);
    send(8'hF0, 0); send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0);
    chk("ext_rel", {31'h0, key_held}, 32'h0);
    send(8'h1C, 0); send(8'hF0, 0);
    do_reset();
    for (int i = 0; i < 100; i++) begin
      send(lc[i % 26], 0); send(8'hF0, 0); send(lc[i % 26], 0);
      if (i == 98) chk("cnt99", {24'h0, press_cnt}, 32'h99);
    end
    chk("cnt_wrap", {24'h0, press_cnt}, 32'h00);
    do_reset();
    send(8'h1C, 0); send(8'hF0, 20); send(8'h1C, 0);
    chk("to_held", {31'h0, key_held}, 32'h1);
    chk("to_cnt", {24'h0, press_cnt}, 32'h01);
    for (int i = 0; i < 400; i++) begin
      logic [7:0] b;
      case ($urandom_range(0, 9))
        0, 1, 2: b = pool[$urandom_range(0, 4)];
        3, 4:    b = 8'hF0;
        5:       b = 8'hE0;
        6:       b = 8'($urandom);
        default: b = m_code;
      endcase
      send(b, $urandom_range(0, 10));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
